// File: rtl/keccak_sbox_share_codec.sv
// rtl/keccak_sbox_share_codec.sv - Boolean share encoder/decoder harness around a DOM-masked Keccak chi row.
// One row in flight: split into shares with xorshift32 masks, wait the sbox latency, recombine.
module keccak_sbox_share_codec #(
    parameter int SHARES  = 2,
    parameter int LATENCY = 1
) (
    input  logic                                  ClkxCI,
    input  logic                                  RstxRBI,
    input  logic                                  InValidxSI,
    output logic                                  InReadyxSO,
    input  logic [4:0]                            PlainxDI,
    input  logic                                  SeedLoadxSI,
    input  logic [31:0]                           SeedxDI,
    output logic [SHARES*5-1:0]                   SharesxDO,
    output logic [(SHARES*SHARES-SHARES)/2*5-1:0] ZxDO,
    input  logic [SHARES*5-1:0]                   SboxOutxDI,
    output logic                                  OutValidxSO,
    input  logic                                  OutReadyxSI,
    output logic [4:0]                            PlainOutxDO
);
    localparam int          SW         = SHARES * 5;
    localparam int          ZW         = (SHARES * SHARES - SHARES) / 2 * 5;
    localparam logic [31:0] PRNG_RESET = 32'h0000_0001;
    localparam logic [1:0]  LAT_INIT   = 2'(LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HOLD
    } state_e;

    state_e        state_q;
    logic [1:0]    cnt_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic [4:0]    plain_out_q;
    logic [4:0]    decode_d;
    logic [31:0]   prng_q;
    logic [31:0]   prng_d;
    logic [31:0]   prng_step;
    logic [SW-1:0] shares_q;
    logic [SW-1:0] shares_d;
    logic [ZW-1:0] z_q;
    logic [ZW-1:0] z_d;
    logic          in_hs;

    function automatic logic [31:0] xorshift32(input logic [31:0] x);
        logic [31:0] t;
        t = x ^ (x << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    assign in_hs     = InValidxSI & in_ready_q;
    assign prng_step = xorshift32(prng_q);

    // A seed load wins over the handshake step; the row still uses step(old R).
    always_comb begin
        prng_d = prng_q;
        if (SeedLoadxSI) begin
            prng_d = (SeedxDI == 32'd0) ? PRNG_RESET : SeedxDI;
        end else if (in_hs) begin
            prng_d = prng_step;
        end
    end

    always_comb begin : encode
        logic [4:0] mask;
        mask     = '0;
        shares_d = '0;
        for (int j = 1; j < SHARES; j++) begin
            shares_d[j*5 +: 5] = prng_step[(j-1)*5 +: 5];
            mask               = mask ^ prng_step[(j-1)*5 +: 5];
        end
        shares_d[4:0] = PlainxDI ^ mask;
        z_d           = prng_step[(SHARES-1)*5 +: ZW];
    end

    always_comb begin
        decode_d = '0;
        for (int i = 0; i < SHARES; i++) begin
            decode_d = decode_d ^ SboxOutxDI[i*5 +: 5];
        end
    end

    always_ff @(posedge ClkxCI or negedge RstxRBI) begin
        if (!RstxRBI) begin
            prng_q   <= PRNG_RESET;
            shares_q <= '0;
            z_q      <= '0;
        end else begin
            prng_q <= prng_d;
            if (in_hs) begin
                shares_q <= shares_d;
                z_q      <= z_d;
            end
        end
    end

    // Handshake flags are registered alongside the state so no input reaches an output combinationally.
    always_ff @(posedge ClkxCI or negedge RstxRBI) begin
        if (!RstxRBI) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            plain_out_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (InValidxSI) begin
                        state_q    <= ST_WAIT;
                        cnt_q      <= LAT_INIT;
                        in_ready_q <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q != 2'd0) begin
                        cnt_q <= cnt_q - 2'd1;
                    end else begin
                        plain_out_q <= decode_d;
                        state_q     <= ST_HOLD;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (OutReadyxSI) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign InReadyxSO  = in_ready_q;
    assign OutValidxSO = out_valid_q;
    assign SharesxDO   = shares_q;
    assign ZxDO        = z_q;
    assign PlainOutxDO = plain_out_q;

endmodule

// File: doc/keccak_sbox_share_codec.md
# keccak_sbox_share_codec

Share encoder/decoder that sits at the far end of the DOM-masked Keccak chi row (`keccak_sbox`). It accepts an unmasked 5-bit row over a valid/ready handshake and splits it into `SHARES` Boolean shares. It drives those shares and the fresh DOM randomness into the sbox, waits the sbox latency, recombines the masked output shares, and returns the unmasked chi result over a second valid/ready handshake. It is the masking harness used for functional bring-up and leakage-evaluation runs of the sbox.

## Interface
- `SHARES`, 2, number of shares; legal range 2..3.
- `LATENCY`, 1, clock edges from the sbox sampling its inputs to its output being valid.
  - 1 for a DOM-pipelined sbox.
  - 0 for a combinational sbox.
  - Legal range 0..3.
- `ClkxCI` in 1: single clock, rising edge.
- `RstxRBI` in 1: reset, asynchronous, active-low.
- `InValidxSI` in 1: plain row valid.
- `InReadyxSO` out 1: codec can accept a row.
- `PlainxDI` in 5: unmasked input row, bit x = lane x.
- `SeedLoadxSI` in 1: load the PRNG seed this cycle.
- `SeedxDI` in 32: PRNG seed value.
- `SharesxDO` out SHARES*5: masked row to the sbox; share i occupies bits [i*5 +: 5].
- `ZxDO` out (SHARES*SHARES-SHARES)/2*5: fresh DOM randomness to the sbox.
- `SboxOutxDI` in SHARES*5: masked chi output from the sbox.
- `OutValidxSO` out 1: result valid.
- `OutReadyxSI` in 1: consumer accepts the result.
- `PlainOutxDO` out 5: unmasked chi result.

## Operation
- PRNG: 32-bit xorshift register `R`.
  - Step function: x ^= x<<13; x ^= x>>17; x ^= x<<5.
  - Reset value is 0x0000_0001.
  - `SeedLoadxSI`=1 loads `SeedxDI`; a seed of 0 loads 0x0000_0001 instead.
  - A seed load takes priority over a step in the same cycle.
  - `R` steps exactly once per input handshake and at no other time.
- Encoding at an input handshake (`InValidxSI`&`InReadyxSO` at a rising edge):
  - Let N = step(R). `R` <= N.
  - Share j (j=1..SHARES-1) <= N[(j-1)*5 +: 5].
  - Share 0 <= `PlainxDI` XOR all other shares.
  - `ZxDO` <= N[(SHARES-1)*5 +: width of ZxDO]. This uses at most 25 bits of N.
- Registering: `SharesxDO` and `ZxDO` are registered and hold their values until the next input handshake.
- Decoding: `PlainOutxDO` <= XOR over i of `SboxOutxDI`[i*5 +: 5]. It is registered at capture and held until the next capture.
- FSM states:
  - IDLE: `InReadyxSO`=1. An input handshake goes to WAIT and loads counter C := LATENCY.
  - WAIT: `InReadyxSO`=0. If C≠0 then C := C−1. If C=0, capture the decode and go to HOLD.
  - HOLD: `OutValidxSO`=1. `OutReadyxSI`=1 at an edge goes to IDLE.
- Handshake outputs are decoded from the state; there are no combinational paths from inputs to outputs.
- Exactly one row is in flight at a time. There is no input acceptance while in WAIT or HOLD.
- `PlainOutxDO` is stable for the whole time `OutValidxSO`=1.
- Reset mid-operation: an asserted `RstxRBI` returns the FSM to IDLE from any state. The in-flight row is dropped, `R` returns to 0x0000_0001, and all registers clear.

## Timing
- Reset values:
  - `InReadyxSO`=1.
  - `OutValidxSO`=0.
  - `SharesxDO`=0.
  - `ZxDO`=0.
  - `PlainOutxDO`=0.
  - FSM in IDLE.
- Sequence for an input handshake at edge k:
  - Shares and randomness are visible after edge k.
  - The sbox samples them at edge k+1.
  - The codec captures the decode at edge k+1+LATENCY.
  - `OutValidxSO`=1 from edge k+1+LATENCY.
- The output handshake at edge m returns the FSM to IDLE; `InReadyxSO`=1 from edge m.
- Minimum spacing between input handshakes is LATENCY+3 cycles (with `OutReadyxSI` tied high).
- `OutReadyxSI` held low keeps the FSM in HOLD indefinitely and the result unchanged.
- `InValidxSI` is ignored outside IDLE.

## Test plan
- Reset, then seed 0 and send `PlainxDI`=0x01 (SHARES=2, LATENCY=1):
  - XOR of the shares = 0x01.
  - `OutValidxSO` rises 2 edges after acceptance.
  - `PlainOutxDO`=0x09.
- Send rows 0x00, 0x1F, 0x06 back-to-back with `OutReadyxSI`=1:
  - Outputs are 0x00, 0x1F, 0x16.
  - Input handshakes are spaced exactly 4 cycles apart.
- Hold `OutReadyxSI`=0 for 10 cycles in HOLD while `InValidxSI`=1 with a new row:
  - `InReadyxSO`=0 throughout.
  - `PlainOutxDO` is unchanged.
  - The new row is accepted only after the output handshake.
- Load seed 0x1234_5678 twice and replay the same row:
  - `SharesxDO` and `ZxDO` are identical on both runs.
  - Share 1 = step(0x1234_5678)[4:0].
- SHARES=3, LATENCY=0: all 32 inputs match a chi golden model, and the XOR of the shares equals the input every time.
- Assert `RstxRBI` during WAIT: all outputs return to their reset values, and no result is emitted for the dropped row.
